// File: rtl/cpu_pkg.sv
// Shared types for the reservation stations: tag type, RS entry layout and
// flag bit positions.
package cpu_pkg;

  typedef logic [3:0] tag_t;

  localparam int FLAG_WB_PC   = 0;
  localparam int FLAG_USE_IMM = 1;

  typedef struct packed {
    logic [7:0]       operand;
    tag_t [1:0]       tag;
    logic [1:0]       rdy;
    logic [1:0][7:0]  val;
    logic [7:0]       wbs;
    logic [7:0]       flags;
    logic [3:0]       robid;
    logic             valid;
  } rs_entry_t;

  // Source b is not needed when the op takes its b operand from the immediate.
  function automatic logic entry_ready(input rs_entry_t e);
    return e.valid & e.rdy[0] & (e.rdy[1] | e.flags[FLAG_USE_IMM]);
  endfunction

endpackage

// File: rtl/rs_oldest_pick.sv
// Lowest-index-first picker: one-hot grant plus binary index of the lowest
// set request bit.
module rs_oldest_pick #(
  parameter int DEPTH = 4,
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [DEPTH-1:0] req_i,
  output logic [DEPTH-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  always_comb begin
    logic found;
    found = 1'b0;
    gnt_o = '0;
    idx_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (req_i[i] && !found) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = IDX_W'(i);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/sel_rs.sv
// Reservation station for the SEL functional unit: collapsing queue of
// dispatched ops, CDB wakeup, oldest-ready issue to the FU.
module sel_rs
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  disp_valid,
  output logic                  disp_ready,
  input  logic [7:0]            disp_operand,
  input  logic [1:0][TAG_W-1:0] disp_tag,
  input  logic [1:0]            disp_rdy,
  input  logic [1:0][7:0]       disp_val,
  input  logic [7:0]            disp_wbs,
  input  logic [7:0]            disp_flags,
  input  logic [3:0]            disp_robid,
  input  logic                  cdb_valid,
  input  logic [TAG_W-1:0]      cdb_id,
  input  logic [7:0]            cdb_val,
  input  logic                  fu_stall,
  input  logic                  flush,
  output logic                  input_transmit,
  output logic [7:0]            operand,
  output logic [1:0][7:0]       depvals,
  output logic [7:0]            wbs,
  output logic [7:0]            flags,
  output logic [3:0]            robid,
  output logic [CNT_W-1:0]      count
);

  rs_entry_t        ent_q [DEPTH];
  rs_entry_t        ent_d [DEPTH];
  rs_entry_t        woken [DEPTH+1];
  rs_entry_t        new_ent;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] append_pos;
  logic [DEPTH-1:0] ready_vec;
  logic [DEPTH-1:0] pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             issue;
  logic             accept;

  assign disp_ready = (count_q < CNT_W'(DEPTH));
  assign count      = count_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ready_vec[i] = entry_ready(ent_q[i]);
    end
  end

  rs_oldest_pick #(.DEPTH(DEPTH)) u_pick (
    .req_i (ready_vec),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign issue  = pick_any & ~fu_stall & ~flush;
  assign accept = disp_valid & disp_ready & ~flush;

  // Wakeup view of every entry; the extra slot feeds the top entry on a shift.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woken[i] = ent_q[i];
      for (int k = 0; k < 2; k++) begin
        if (cdb_valid && ent_q[i].valid && !ent_q[i].rdy[k] &&
            (cdb_id == ent_q[i].tag[k])) begin
          woken[i].rdy[k] = 1'b1;
          woken[i].val[k] = cdb_val;
        end
      end
    end
    woken[DEPTH] = '0;
  end

  // Incoming op, with a same-cycle CDB broadcast captured directly.
  always_comb begin
    new_ent         = '0;
    new_ent.operand = disp_operand;
    new_ent.wbs     = disp_wbs;
    new_ent.flags   = disp_flags;
    new_ent.robid   = disp_robid;
    new_ent.valid   = 1'b1;
    for (int k = 0; k < 2; k++) begin
      new_ent.tag[k] = tag_t'(disp_tag[k]);
      new_ent.rdy[k] = disp_rdy[k];
      new_ent.val[k] = disp_val[k];
      if (!disp_rdy[k] && cdb_valid && (cdb_id == disp_tag[k])) begin
        new_ent.rdy[k] = 1'b1;
        new_ent.val[k] = cdb_val;
      end
    end
  end

  assign append_pos = count_q - CNT_W'(issue);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (issue && (i >= int'(pick_idx))) begin
        ent_d[i] = woken[i+1];
      end else begin
        ent_d[i] = woken[i];
      end
      if (accept && (CNT_W'(i) == append_pos)) begin
        ent_d[i] = new_ent;
      end
      if (flush) begin
        ent_d[i] = '0;
      end
    end
    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(accept) - CNT_W'(issue);
    end
  end

  always_comb begin
    input_transmit = 1'b0;
    operand        = '0;
    depvals        = '0;
    wbs            = '0;
    flags          = '0;
    robid          = '0;
    if (issue) begin
      input_transmit = 1'b1;
      operand        = ent_q[pick_idx].operand;
      depvals        = ent_q[pick_idx].val;
      wbs            = ent_q[pick_idx].wbs;
      flags          = ent_q[pick_idx].flags;
      robid          = ent_q[pick_idx].robid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

endmodule
